peak_meter: RTL and testbench

- Per-channel peak/clip metering stage directly downstream of the ADAT receiver, in the oversampling clock domain.
- Consumes the 8-channel decoded audio bus and its data_valid strobe.
- Keeps a peak-hold-with-decay level and a clip latch per channel.
- Drives a selectable-channel readout and an 8-LED 6 dB/step bargraph; replaces the raw abs-of-channel-0 LED drive.
- Channels are processed time-multiplexed, one per clock, so one magnitude/compare datapath is shared.

---
 rtl/peak_meter.sv | 202 ++++++++++++++++++++
 tb/tb_peak_meter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/peak_meter.sv
// -----------------------------------------------------------------------------
// peak_meter
//
// Per-channel peak-hold-with-decay and clip metering for the decoded ADAT
// audio bus. A frame is captured on data_valid and its channels are then
// updated one per clock through a single shared magnitude/compare datapath.
//
// Ports:
//   clk            oversampling clock
//   rst            synchronous active-high reset
//   data_valid     one-cycle strobe, audio_bus holds a new frame
//   audio_bus      NUM_CHANNELS signed samples, channel c at [c*SAMPLE_WIDTH +: SAMPLE_WIDTH]
//   sel            channel shown on peak_out / led
//   busy           high while a captured frame is being processed
//   frame_done     one-cycle pulse after the last channel of a frame updated
//   peak_out       peak level of channel sel (registered)
//   led            8-step thermometer bargraph of channel sel, 6 dB per step
//   clip           per-channel clip flags
//   overrun_count  saturating count of frames dropped while busy
// -----------------------------------------------------------------------------
module peak_meter #(
   parameter int NUM_CHANNELS = 8,
   parameter int SAMPLE_WIDTH = 24,
   parameter int HOLD_SAMPLES = 4800,
   parameter int DECAY_STEP   = 256,
   parameter int CLIP_LEVEL   = 8388600,
   parameter int CLIP_HOLD    = 24000
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   data_valid,
   input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0]   audio_bus,
   input  logic [$clog2(NUM_CHANNELS)-1:0]        sel,
   output logic                                   busy,
   output logic                                   frame_done,
   output logic [SAMPLE_WIDTH-2:0]                peak_out,
   output logic [7:0]                             led,
   output logic [NUM_CHANNELS-1:0]                clip,
   output logic [7:0]                             overrun_count
);

   localparam int MAG_W  = SAMPLE_WIDTH - 1;
   localparam int IDX_W  = $clog2(NUM_CHANNELS);
   localparam int HOLD_W = $clog2(HOLD_SAMPLES + 1);
   localparam int CLIP_W = $clog2(CLIP_HOLD + 1);

   localparam logic [MAG_W-1:0]  DECAY_V      = MAG_W'(DECAY_STEP);
   localparam logic [MAG_W-1:0]  CLIP_LEVEL_V = MAG_W'(CLIP_LEVEL);
   localparam logic [HOLD_W-1:0] HOLD_V       = HOLD_W'(HOLD_SAMPLES);
   localparam logic [CLIP_W-1:0] CLIP_HOLD_V  = CLIP_W'(CLIP_HOLD);
   localparam logic [IDX_W-1:0]  LAST_IDX     = IDX_W'(NUM_CHANNELS - 1);
   localparam logic [IDX_W:0]    NUM_CH_V     = (IDX_W + 1)'(NUM_CHANNELS);

   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_PROCESS = 1'b1;

   logic [0:0]              state_reg;
   logic [IDX_W-1:0]        idx_reg;
   logic [SAMPLE_WIDTH-1:0] frame_reg    [NUM_CHANNELS];
   logic [MAG_W-1:0]        peak_reg     [NUM_CHANNELS];
   logic [HOLD_W-1:0]       hold_reg     [NUM_CHANNELS];
   logic [CLIP_W-1:0]       clip_cnt_reg [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] clip_reg;
   logic                    frame_done_reg;
   logic [7:0]              overrun_reg;
   logic [MAG_W-1:0]        peak_out_reg;
   logic [7:0]              led_reg;

   // ---------------------------------------------------------------- datapath
   logic [SAMPLE_WIDTH-1:0] cur_sample;
   logic [SAMPLE_WIDTH-1:0] neg_sample;
   logic [MAG_W-1:0]        mag;
   logic [MAG_W-1:0]        cur_peak;
   logic [MAG_W-1:0]        decayed;
   logic [HOLD_W-1:0]       cur_hold;
   logic [CLIP_W-1:0]       cur_clip_cnt;
   logic [MAG_W-1:0]        peak_next;
   logic [HOLD_W-1:0]       hold_next;
   logic [CLIP_W-1:0]       clip_cnt_next;

   assign cur_sample   = frame_reg[idx_reg];
   assign neg_sample   = '0 - cur_sample;
   assign cur_peak     = peak_reg[idx_reg];
   assign cur_hold     = hold_reg[idx_reg];
   assign cur_clip_cnt = clip_cnt_reg[idx_reg];

   always_comb begin
      // The most negative code has no positive twin; clamp it to full scale.
      mag = cur_sample[MAG_W-1:0];
      if (cur_sample == {1'b1, {MAG_W{1'b0}}}) begin
         mag = '1;
      end else if (cur_sample[SAMPLE_WIDTH-1]) begin
         mag = neg_sample[MAG_W-1:0];
      end
   end

   // Decay floors at zero rather than wrapping.
   assign decayed = (cur_peak >= DECAY_V) ? (cur_peak - DECAY_V) : '0;

   always_comb begin
      peak_next = cur_peak;
      hold_next = cur_hold;
      if (mag >= cur_peak) begin
         peak_next = mag;
         hold_next = HOLD_V;
      end else if (cur_hold != '0) begin
         hold_next = cur_hold - HOLD_W'(1);
      end else begin
         peak_next = (mag > decayed) ? mag : decayed;
      end
   end

   always_comb begin
      clip_cnt_next = cur_clip_cnt;
      if (mag >= CLIP_LEVEL_V) begin
         clip_cnt_next = CLIP_HOLD_V;
      end else if (cur_clip_cnt != '0) begin
         clip_cnt_next = cur_clip_cnt - CLIP_W'(1);
      end
   end

   // ----------------------------------------------------------------- readout
   logic [MAG_W-1:0] sel_peak;
   logic [7:0]       led_next;

   always_comb begin
      sel_peak = '0;
      if ({1'b0, sel} < NUM_CH_V) begin
         sel_peak = peak_reg[sel];
      end
   end

   // Bar k lights when any bit at or above weight 2^(MAG_W-8+k) is set,
   // giving one LED per 6 dB across the top eight octaves.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_led
         assign led_next[gi] = |sel_peak[MAG_W-1:MAG_W-8+gi];
      end
   endgenerate

   // --------------------------------------------------------------- registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         idx_reg        <= '0;
         frame_done_reg <= 1'b0;
         overrun_reg    <= '0;
         peak_out_reg   <= '0;
         led_reg        <= '0;
         clip_reg       <= '0;
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            frame_reg[c]    <= '0;
            peak_reg[c]     <= '0;
            hold_reg[c]     <= '0;
            clip_cnt_reg[c] <= '0;
         end
      end else begin
         frame_done_reg <= 1'b0;
         peak_out_reg   <= sel_peak;
         led_reg        <= led_next;

         case (state_reg)
            ST_IDLE: begin
               if (data_valid) begin
                  for (int c = 0; c < NUM_CHANNELS; c++) begin
                     frame_reg[c] <= audio_bus[c*SAMPLE_WIDTH +: SAMPLE_WIDTH];
                  end
                  idx_reg   <= '0;
                  state_reg <= ST_PROCESS;
               end
            end
            default: begin
               peak_reg[idx_reg]     <= peak_next;
               hold_reg[idx_reg]     <= hold_next;
               clip_cnt_reg[idx_reg] <= clip_cnt_next;
               clip_reg[idx_reg]     <= (clip_cnt_next != '0);

               // A frame arriving while busy is dropped, not queued.
               if (data_valid && (overrun_reg != 8'hFF)) begin
                  overrun_reg <= overrun_reg + 8'd1;
               end

               if (idx_reg == LAST_IDX) begin
                  state_reg      <= ST_IDLE;
                  frame_done_reg <= 1'b1;
               end else begin
                  idx_reg <= idx_reg + IDX_W'(1);
               end
            end
         endcase
      end
   end

   assign busy          = (state_reg == ST_PROCESS);
   assign frame_done    = frame_done_reg;
   assign peak_out      = peak_out_reg;
   assign led           = led_reg;
   assign clip          = clip_reg;
   assign overrun_count = overrun_reg;

endmodule

// File: tb/tb_peak_meter.sv
// -----------------------------------------------------------------------------
// tb_peak_meter
//
// Scoreboard bench for peak_meter. The stimulus side updates a behavioural
// per-channel level model when it issues a frame and queues the expected
// readout; a monitor pops and compares whenever frame_done pulses.
// -----------------------------------------------------------------------------
module tb_peak_meter;

   localparam int NCH   = 8;
   localparam int W     = 24;
   localparam int HOLD  = 2;
   localparam int DECAY = 4096;
   localparam int CLIPL = 8388600;
   localparam int CLIPH = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             data_valid;
   logic [NCH*W-1:0] audio_bus;
   logic [2:0]       sel;
   logic             busy;
   logic             frame_done;
   logic [W-2:0]     peak_out;
   logic [7:0]       led;
   logic [NCH-1:0]   clip;
   logic [7:0]       overrun_count;

   peak_meter #(
      .NUM_CHANNELS(NCH), .SAMPLE_WIDTH(W), .HOLD_SAMPLES(HOLD),
      .DECAY_STEP(DECAY), .CLIP_LEVEL(CLIPL), .CLIP_HOLD(CLIPH)
   ) dut (
      .clk(clk), .rst(rst), .data_valid(data_valid), .audio_bus(audio_bus),
      .sel(sel), .busy(busy), .frame_done(frame_done), .peak_out(peak_out),
      .led(led), .clip(clip), .overrun_count(overrun_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int sel_v;
      int peak;
      int led_v;
      int clip_v;
      int ovr;
      int due;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model state
   int m_peak [NCH];
   int m_hold [NCH];
   int m_clipc[NCH];
   int m_ovr;
   int fs     [NCH];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   function automatic int mag_of(input int x);
      if (x == -(1 << 23)) return (1 << 23) - 1;
      return (x < 0) ? -x : x;
   endfunction

   function automatic int led_of(input int p);
      int r = 0;
      for (int k = 0; k < 8; k++) if (p >= (1 << (15 + k))) r |= (1 << k);
      return r;
   endfunction

   function automatic int rand_sample();
      case ($urandom_range(0, 9))
         0: return 0;
         1: return -(1 << 23);
         2: return (1 << 23) - 1;
         3: return CLIPL;
         4: return CLIPL - 1;
         5: return -CLIPL;
         6: return int'($urandom_range(0, 1 << 16));
         7: return -int'($urandom_range(0, 1 << 20));
         default: return int'($urandom_range(0, (1 << 24) - 1)) - (1 << 23);
      endcase
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_peak[c] = 0; m_hold[c] = 0; m_clipc[c] = 0;
      end
      m_ovr = 0;
   endtask

   task automatic model_frame();
      int m, d;
      for (int c = 0; c < NCH; c++) begin
         m = mag_of(fs[c]);
         if (m >= m_peak[c]) begin
            m_peak[c] = m;
            m_hold[c] = HOLD;
         end else if (m_hold[c] != 0) begin
            m_hold[c]--;
         end else begin
            d = m_peak[c] - DECAY;
            if (d < 0) d = 0;
            m_peak[c] = (m > d) ? m : d;
         end
         if (m >= CLIPL) m_clipc[c] = CLIPH;
         else if (m_clipc[c] != 0) m_clipc[c]--;
      end
   endtask

   task automatic clear_frame();
      for (int c = 0; c < NCH; c++) fs[c] = 0;
   endtask

   task automatic random_frame();
      for (int c = 0; c < NCH; c++) fs[c] = rand_sample();
   endtask

   task automatic drive_bus();
      for (int c = 0; c < NCH; c++) audio_bus[c*W +: W] = fs[c][W-1:0];
   endtask

   task automatic garbage_bus();
      for (int c = 0; c < NCH; c++) audio_bus[c*W +: W] = W'($urandom);
   endtask

   // Issue fs[] as a frame; drop pulses land on PROCESS cycles
   // drop_start .. drop_start+drops-1 (0 = first PROCESS cycle).
   task automatic send_frame(input int sel_v, input int drop_start, input int drops);
      exp_t e;
      int   cv = 0;
      model_frame();
      m_ovr = (m_ovr + drops > 255) ? 255 : m_ovr + drops;
      for (int c = 0; c < NCH; c++) if (m_clipc[c] != 0) cv |= (1 << c);
      @(negedge clk);
      e.sel_v  = sel_v;
      e.peak   = m_peak[sel_v];
      e.led_v  = led_of(m_peak[sel_v]);
      e.clip_v = cv;
      e.ovr    = m_ovr;
      e.due    = cyc + NCH + 1;
      sb.push_back(e);
      drive_bus();
      sel        = 3'(sel_v);
      data_valid = 1'b1;
      @(negedge clk);
      check("busy_in_process", busy, 1);
      for (int i = 0; i < NCH; i++) begin
         data_valid = (i >= drop_start) && (i < drop_start + drops);
         garbage_bus();
         @(negedge clk);
      end
      data_valid = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic reset_mid_frame();
      random_frame();
      @(negedge clk);
      drive_bus();
      data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      model_reset();
      check("midrst_busy", busy, 0);
      check("midrst_frame_done", frame_done, 0);
      check("midrst_clip", clip, 0);
      check("midrst_overrun", overrun_count, 0);
      rst = 1'b0;
      for (int s = 0; s < NCH; s++) begin
         sel = 3'(s);
         @(negedge clk);
         @(negedge clk);
         check("midrst_peak", peak_out, 0);
         check("midrst_led", led, 0);
      end
   endtask

   // Monitor: compares each completed frame against the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (frame_done === 1'b1) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL frame_done_unexpected: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
               e = sb.pop_front();
               check("frame_done_time", 64'(cyc), 64'(e.due));
               check("clip", clip, 64'(e.clip_v));
               check("overrun_count", overrun_count, 64'(e.ovr));
               check("busy_after_frame", busy, 0);
               @(negedge clk);
               check("peak_out", peak_out, 64'(e.peak));
               check("led", led, 64'(e.led_v));
            end
         end
      end
   end

   initial begin
      int budget;
      rst        = 1'b1;
      data_valid = 1'b0;
      audio_bus  = '0;
      sel        = '0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_peak_out", peak_out, 0);
      check("rst_led", led, 0);
      check("rst_clip", clip, 0);
      check("rst_overrun", overrun_count, 0);
      rst = 1'b0;

      // All-zero frame
      clear_frame();
      send_frame(0, 0, 0);

      // Ch3 = -0x100000 on channel 3 readout
      clear_frame();
      fs[3] = -32'sh100000;
      send_frame(3, 0, 0);

      // Most negative code on ch0, then clip hold expiry
      clear_frame();
      fs[0] = -(1 << 23);
      send_frame(0, 0, 0);
      clear_frame();
      repeat (3) send_frame(0, 0, 0);

      // Hold then decay on ch1
      clear_frame();
      fs[1] = 32'h8000;
      send_frame(1, 0, 0);
      clear_frame();
      repeat (12) send_frame(1, 0, 0);

      // Overruns: 3 cycles after data_valid, and on the last PROCESS cycle
      clear_frame();
      fs[3] = 32'h123456;
      send_frame(3, 2, 1);
      clear_frame();
      send_frame(3, NCH - 1, 1);

      // Drive overrun_count into saturation
      for (int f = 0; f < 38; f++) begin
         random_frame();
         send_frame($urandom_range(0, NCH - 1), 0, NCH);
      end

      // Reset in the 4th PROCESS cycle, then normal frames
      reset_mid_frame();
      random_frame();
      send_frame(2, 0, 0);

      for (int f = 0; f < 40; f++) begin
         int d, st;
         if ($urandom_range(0, 9) < 4) clear_frame();
         else random_frame();
         d  = $urandom_range(0, 2);
         st = $urandom_range(0, NCH - d);
         send_frame($urandom_range(0, NCH - 1), st, d);
      end

      budget = 0;
      while (sb.size() != 0 && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
